// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: carry-save running sum, one 3:2 compression
// per accepted word, then a CHUNK-bit-per-cycle ripple resolve with exact overflow.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ACCUM   | accepting words, compressing each into S/C (in_ready=1)
// RESOLVE | rippling S + (C<<1) one slice per cycle into result
// OUTPUT  | result presented (out_valid=1) until out_ready
module csa_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12,
  parameter int CHUNK     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 overflow
);

  localparam int NSLICE = (ACC_WIDTH + CHUNK - 1) / CHUNK;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   s_q, s_d;
  logic [ACC_WIDTH-1:0]   c_q, c_d;
  logic [ACC_WIDTH-1:0]   res_q, res_d;
  logic                   ovf_q, ovf_d;
  logic                   cin_q, cin_d;
  logic [KW-1:0]          k_q, k_d;

  logic [ACC_WIDTH-1:0]   c2;
  logic [ACC_WIDTH-1:0]   d_ext;
  logic [ACC_WIDTH-1:0]   csa_sum;
  logic [ACC_WIDTH-1:0]   csa_carry;
  logic [ACC_WIDTH-1:0]   slice_res;
  logic                   slice_cout;
  logic                   in_fire;
  logic                   out_fire;
  logic                   last_slice;

  // C[i] weighs 2^(i+1); the top bit falls off on every shift and is tracked in ovf.
  assign c2    = {c_q[ACC_WIDTH-2:0], 1'b0};
  assign d_ext = ACC_WIDTH'(in_data);

  // Columns below WIDTH are full adders; above WIDTH the operand is zero so half adders suffice.
  always_comb begin
    csa_sum   = '0;
    csa_carry = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (i < WIDTH) begin
        csa_sum[i]   = s_q[i] ^ c2[i] ^ d_ext[i];
        csa_carry[i] = (s_q[i] & c2[i]) | (s_q[i] & d_ext[i]) | (c2[i] & d_ext[i]);
      end else begin
        csa_sum[i]   = s_q[i] ^ c2[i];
        csa_carry[i] = s_q[i] & c2[i];
      end
    end
  end

  // Ripple add of slice k only; bits outside the slice keep the previous result.
  always_comb begin
    logic carry;
    slice_res = res_q;
    carry     = cin_q;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (KW'(i / CHUNK) == k_q) begin
        slice_res[i] = s_q[i] ^ c2[i] ^ carry;
        carry        = (s_q[i] & c2[i]) | (carry & (s_q[i] ^ c2[i]));
      end
    end
    slice_cout = carry;
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == OUTPUT);
  assign out_data   = out_valid ? res_q : '0;
  assign overflow   = out_valid & ovf_q;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign last_slice = (k_q == KW'(NSLICE - 1));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    cin_d   = cin_q;
    k_d     = k_q;
    unique case (state_q)
      ACCUM: begin
        if (in_fire) begin
          s_d = csa_sum;
          c_d = csa_carry;
          if (c_q[ACC_WIDTH-1]) ovf_d = 1'b1;
          if (in_last) begin
            state_d = RESOLVE;
            k_d     = '0;
            cin_d   = 1'b0;
          end
        end
      end
      RESOLVE: begin
        res_d = slice_res;
        cin_d = slice_cout;
        if (last_slice) begin
          ovf_d   = ovf_q | c_q[ACC_WIDTH-1] | slice_cout;
          state_d = OUTPUT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      OUTPUT: begin
        if (out_fire) begin
          s_d     = '0;
          c_d     = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      cin_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      cin_q   <= cin_d;
      k_q     <= k_d;
    end
  end

endmodule
